// File: rtl/tcb_pkg.sv
// Shared definitions for the TCB classifier host-side loader: FSM states, bus
// geometry defaults and the result code reported on timeout or framing error.
package tcb_pkg;

  localparam int unsigned TCB_PIX_W = 8;
  localparam int unsigned TCB_N_PIX = 121;
  localparam int unsigned TCB_BUS_W = 1024;

  localparam logic [31:0] TCB_TMO_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StLoad,
    StFire,
    StWait,
    StResult
  } tcb_state_e;

endpackage

// File: rtl/tcb_img_loader_if.sv
// Pixel stream, classifier start/done and result handshake of the image loader.
// master is the loader side, slave is the surrounding host/classifier.
interface tcb_img_loader_if #(
  parameter int unsigned PIX_W = tcb_pkg::TCB_PIX_W,
  parameter int unsigned BUS_W = tcb_pkg::TCB_BUS_W
);

  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic             pix_last;
  logic [BUS_W-1:0] img_source;
  logic             valid_top;
  logic             ready_top;
  logic [31:0]      number;
  logic [31:0]      res_data;
  logic             res_err;
  logic             res_valid;
  logic             res_ready;

  modport master (
    input  pix_data, pix_valid, pix_last, ready_top, number, res_ready,
    output pix_ready, img_source, valid_top, res_data, res_err, res_valid
  );

  modport slave (
    output pix_data, pix_valid, pix_last, ready_top, number, res_ready,
    input  pix_ready, img_source, valid_top, res_data, res_err, res_valid
  );

endinterface

// File: rtl/tcb_pix_packer.sv
// Packs the byte-serial pixel stream into the flat image register, counts pixels
// and tracks framing errors (pix_last misplaced) for the current image.
module tcb_pix_packer import tcb_pkg::*; #(
  parameter int unsigned PIX_W = TCB_PIX_W,
  parameter int unsigned N_PIX = TCB_N_PIX,
  parameter int unsigned BUS_W = TCB_BUS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_last,
  input  logic             clear,
  output logic             img_done,
  output logic             frame_err,
  output logic [BUS_W-1:0] img_source
);

  localparam int unsigned IMG_W = N_PIX * PIX_W;
  localparam int unsigned CNT_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_PIX - 1);

  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             err_q, err_d;
  logic [IMG_W-1:0] img_q;
  logic [N_PIX-1:0] lane_we;
  logic             at_last;
  logic             bad_frame;

  assign at_last   = (pix_cnt_q == LastIdx);
  assign bad_frame = (pix_last != at_last);
  assign img_done  = accept & at_last;
  // Includes the pixel being accepted this cycle so the FSM sees it on img_done.
  assign frame_err = err_q | (accept & bad_frame);

  always_comb begin
    lane_we = '0;
    for (int i = 0; i < N_PIX; i++) begin
      lane_we[i] = accept && (pix_cnt_q == CNT_W'(i));
    end
  end

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    err_d     = err_q;
    if (clear) begin
      pix_cnt_d = '0;
      err_d     = 1'b0;
    end else if (accept) begin
      pix_cnt_d = at_last ? '0 : pix_cnt_q + 1'b1;
      err_d     = err_q | bad_frame;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img_q <= '0;
    end else begin
      for (int i = 0; i < N_PIX; i++) begin
        if (lane_we[i]) img_q[i*PIX_W +: PIX_W] <= pix_data;
      end
    end
  end

  // Lanes above the image are tied to zero by the zero-extension.
  assign img_source = BUS_W'(img_q);

endmodule

// File: rtl/tcb_img_loader.sv
// Host-side driver for the TCB classifier: loads one image, starts the classifier,
// waits for its answer with a timeout and returns the class on a result port.
module tcb_img_loader import tcb_pkg::*; #(
  parameter int unsigned PIX_W   = TCB_PIX_W,
  parameter int unsigned N_PIX   = TCB_N_PIX,
  parameter int unsigned BUS_W   = TCB_BUS_W,
  parameter int unsigned TMO_CYC = 65535
) (
  input logic              clk,
  input logic              rst,
  tcb_img_loader_if.master bus
);

  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TMO_CYC - 1);

  tcb_state_e       state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0]      res_data_q, res_data_d;
  logic             res_err_q, res_err_d;
  logic             res_valid_q, res_valid_d;
  logic             valid_top_q;
  logic             live_q;
  logic             accept;
  logic             img_done;
  logic             frame_err;
  logic             clear;

  // live_q keeps pix_ready low while reset is applied and for the release cycle.
  assign bus.pix_ready = live_q & (state_q == StLoad);
  assign accept        = bus.pix_valid & bus.pix_ready;

  tcb_pix_packer #(
    .PIX_W (PIX_W),
    .N_PIX (N_PIX),
    .BUS_W (BUS_W)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .pix_data   (bus.pix_data),
    .pix_last   (bus.pix_last),
    .clear      (clear),
    .img_done   (img_done),
    .frame_err  (frame_err),
    .img_source (bus.img_source)
  );

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    clear       = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (img_done) begin
          if (frame_err) begin
            state_d     = StResult;
            res_data_d  = TCB_TMO_RESULT;
            res_err_d   = 1'b1;
            res_valid_d = 1'b1;
          end else begin
            state_d = StFire;
          end
        end
      end
      StFire: begin
        state_d   = StWait;
        tmo_cnt_d = '0;
      end
      StWait: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        // A done pulse on the last allowed cycle still beats the timeout.
        if (bus.ready_top) begin
          state_d     = StResult;
          res_data_d  = bus.number;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
        end else if (tmo_cnt_q == TmoLast) begin
          state_d     = StResult;
          res_data_d  = TCB_TMO_RESULT;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
        end
      end
      StResult: begin
        if (bus.res_ready) begin
          state_d     = StLoad;
          res_valid_d = 1'b0;
          clear       = 1'b1;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StLoad;
      tmo_cnt_q   <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      valid_top_q <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      valid_top_q <= (state_d == StFire);
      live_q      <= 1'b1;
    end
  end

  assign bus.valid_top = valid_top_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign bus.res_valid = res_valid_q;

endmodule

// File: tb/tb_tcb_img_loader.sv
// Scoreboard bench for tcb_img_loader: a long-timeout instance for normal traffic and
// a TMO_CYC=16 instance for timeout boundaries, selected onto shared stimulus wires.
module tb_tcb_img_loader;
  import tcb_pkg::*;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned N_PIX = 121;
  localparam int unsigned BUS_W = 1024;
  localparam int          TMO_A = 1000;
  localparam int          TMO_B = 16;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_last = 1'b0;
  logic        ready_top = 1'b0;
  logic        res_ready = 1'b0;
  logic [31:0] number = '0;
  int          rr_mode = 0;

  int n_chk = 0;
  int n_fail = 0;
  int n_fired = 0;
  int vt_count = 0;
  int cyc = 0, acc_cnt = 0, done_cyc = 0, vt_cyc = 0;
  logic prev_rv = 1'b0;

  logic [7:0]       pix [N_PIX];
  res_t             exp_q[$];
  logic [BUS_W-1:0] exp_img_q[$];

  tcb_img_loader_if #(.PIX_W(PIX_W), .BUS_W(BUS_W)) bus_a ();
  tcb_img_loader_if #(.PIX_W(PIX_W), .BUS_W(BUS_W)) bus_b ();

  assign bus_a.pix_data  = pix_data;
  assign bus_a.pix_last  = pix_last;
  assign bus_a.number    = number;
  assign bus_a.pix_valid = pix_valid & ~sel;
  assign bus_a.ready_top = ready_top & ~sel;
  assign bus_a.res_ready = res_ready & ~sel;
  assign bus_b.pix_data  = pix_data;
  assign bus_b.pix_last  = pix_last;
  assign bus_b.number    = number;
  assign bus_b.pix_valid = pix_valid & sel;
  assign bus_b.ready_top = ready_top & sel;
  assign bus_b.res_ready = res_ready & sel;

  tcb_img_loader #(.PIX_W(PIX_W), .N_PIX(N_PIX), .BUS_W(BUS_W), .TMO_CYC(TMO_A)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  tcb_img_loader #(.PIX_W(PIX_W), .N_PIX(N_PIX), .BUS_W(BUS_W), .TMO_CYC(TMO_B)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  logic             cur_pix_ready, cur_valid_top, cur_res_err, cur_res_valid;
  logic [31:0]      cur_res_data;
  logic [BUS_W-1:0] cur_img;
  assign cur_pix_ready = sel ? bus_b.pix_ready  : bus_a.pix_ready;
  assign cur_valid_top = sel ? bus_b.valid_top  : bus_a.valid_top;
  assign cur_res_err   = sel ? bus_b.res_err    : bus_a.res_err;
  assign cur_res_valid = sel ? bus_b.res_valid  : bus_a.res_valid;
  assign cur_res_data  = sel ? bus_b.res_data   : bus_a.res_data;
  assign cur_img       = sel ? bus_b.img_source : bus_a.img_source;

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  function automatic void check_wide(string name, logic [BUS_W-1:0] act,
                                     logic [BUS_W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  function automatic void fail_now(string name, string what);
    n_chk++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endfunction

  // Result consumer: 0 = always ready, 1 = stall, 2 = random.
  initial begin : consumer
    forever begin
      @(posedge clk);
      #1;
      res_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  initial begin : monitor
    res_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        acc_cnt = 0;
        prev_rv = 1'b0;
      end else begin
        if (pix_valid && cur_pix_ready) begin
          acc_cnt++;
          if (acc_cnt == N_PIX) begin
            acc_cnt  = 0;
            done_cyc = cyc;
          end
        end
        if (cur_valid_top) begin
          vt_count++;
          vt_cyc = cyc;
          check("valid_top_latency", cyc, done_cyc + 1);
          if (exp_img_q.size() == 0) fail_now("valid_top_unexpected", "pulse with no image due");
          else check_wide("img_source", cur_img, exp_img_q.pop_front());
        end
        if (cur_res_valid && !prev_rv && exp_q.size() > 0 && exp_q[0].lat >= 0)
          check("res_latency", cyc - vt_cyc, exp_q[0].lat);
        if (cur_res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("res_unexpected", "result handshake with no result due");
          end else begin
            e = exp_q.pop_front();
            check("res_data", cur_res_data, e.data);
            check("res_err", 32'(cur_res_err), 32'(e.err));
            check("pixels_consumed_mod_n", acc_cnt, 0);
          end
        end
        prev_rv = cur_res_valid;
      end
    end
  end

  // Reference: an image answers 'num' if the classifier replies within the timeout
  // window (delay in 1..TMO cycles after valid_top), otherwise the timeout code; a
  // misplaced pix_last never starts the classifier and reports the error code.
  task automatic send_image(input int last_pos, input int delay, input logic [31:0] num,
                            input int gap_max);
    res_t             e;
    logic             ferr;
    logic [BUS_W-1:0] img;
    int               tmo;
    int               waited;
    int               g;
    tmo  = sel ? TMO_B : TMO_A;
    ferr = (last_pos != N_PIX - 1);
    img  = '0;
    for (int k = 0; k < N_PIX; k++) img[k*PIX_W +: PIX_W] = pix[k];
    if (ferr) begin
      e.data = 32'hFFFF_FFFF; e.err = 1'b1; e.lat = -1;
    end else if (delay >= 1 && delay <= tmo) begin
      e.data = num;           e.err = 1'b0; e.lat = delay + 1;
    end else begin
      e.data = 32'hFFFF_FFFF; e.err = 1'b1; e.lat = tmo + 1;
    end
    exp_q.push_back(e);
    if (!ferr) begin
      exp_img_q.push_back(img);
      n_fired++;
    end
    for (int k = 0; k < N_PIX; k++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      if (g > 0) begin
        pix_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      pix_valid = 1'b1;
      pix_data  = pix[k];
      pix_last  = (k == last_pos);
      waited    = 0;
      forever begin
        @(negedge clk);
        if (cur_pix_ready) break;
        waited++;
        if (waited > 4000) begin
          fail_now("pix_ready_wait", "pix_ready stayed 0 for 4000 cycles");
          pix_valid = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    if (!ferr) begin
      waited = 0;
      forever begin
        @(negedge clk);
        if (cur_valid_top) break;
        waited++;
        if (waited > 8) begin
          fail_now("valid_top_wait", "no valid_top within 8 cycles of last pixel");
          return;
        end
      end
      for (int c = 1; c <= delay; c++) begin
        @(posedge clk);
        #1;
        if (c == delay) begin
          ready_top = 1'b1;
          number    = num;
        end
      end
      if (delay > 0) begin
        @(posedge clk);
        #1;
        ready_top = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      w++;
      if (w > 5000) begin
        fail_now("drain", "results still pending after 5000 cycles");
        exp_q.delete();
        exp_img_q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(string tag);
    check_wide({tag, "_img_source"}, cur_img, '0);
    check({tag, "_valid_top"}, 32'(cur_valid_top), 0);
    check({tag, "_res_valid"}, 32'(cur_res_valid), 0);
    check({tag, "_res_err"}, 32'(cur_res_err), 0);
    check({tag, "_res_data"}, cur_res_data, 0);
    check({tag, "_pix_ready"}, 32'(cur_pix_ready), 0);
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    @(negedge clk);
    check("pix_ready_at_release", 32'(cur_pix_ready), 0);
    @(negedge clk);
    check("pix_ready_after_release", 32'(cur_pix_ready), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    int vt0;
    int w;
    #2;
    check_reset_outputs("reset");
    release_reset();

    // Ramp image, answer 7 after 40 cycles, then stall the result port.
    for (int k = 0; k < N_PIX; k++) pix[k] = 8'(k);
    vt0     = vt_count;
    rr_mode = 1;
    send_image(N_PIX - 1, 40, 32'd7, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      pix_valid = ~pix_valid;
      ready_top = ~ready_top;
      number    = 32'd3;
      @(negedge clk);
      check("stall_pix_ready", 32'(cur_pix_ready), 0);
      check("stall_res_data", cur_res_data, 32'd7);
      check("stall_res_valid", 32'(cur_res_valid), 1);
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    ready_top = 1'b0;
    rr_mode   = 0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(cur_res_valid && res_ready) && w < 10);
    @(negedge clk);
    check("load_after_ack", 32'(cur_pix_ready), 1);
    check("res_valid_after_ack", 32'(cur_res_valid), 0);
    @(posedge clk);
    #1;
    check("single_valid_top", vt_count, vt0 + 1);

    // Short-timeout instance: timeout with a late done pulse, then the window edges.
    sel = 1'b1;
    for (int k = 0; k < N_PIX; k++) pix[k] = 8'($urandom);
    rr_mode = 1;
    send_image(N_PIX - 1, TMO_B + 4, 32'h55, 0);
    rr_mode = 0;
    drain();
    for (int k = 0; k < N_PIX; k++) pix[k] = 8'($urandom);
    send_image(N_PIX - 1, TMO_B, 32'h1234, 0);
    drain();
    send_image(N_PIX - 1, TMO_B + 1, 32'h99, 0);
    drain();
    sel = 1'b0;

    // Framing errors: early pix_last, and missing pix_last.
    vt0 = vt_count;
    for (int k = 0; k < N_PIX; k++) pix[k] = 8'($urandom);
    send_image(60, 0, 32'd0, 0);
    drain();
    send_image(-1, 0, 32'd0, 1);
    drain();
    check("no_valid_top_on_frame_err", vt_count, vt0);

    // Async reset in the middle of WAIT.
    for (int k = 0; k < N_PIX; k++) pix[k] = 8'($urandom);
    send_image(N_PIX - 1, 0, 32'd0, 0);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_wait_reset");
    exp_q.delete();
    exp_img_q.delete();
    release_reset();
    for (int k = 0; k < N_PIX; k++) pix[k] = 8'($urandom);
    send_image(N_PIX - 1, 25, 32'hABCD, 0);
    drain();

    // Back-to-back images with random gaps and random result back-pressure.
    vt0     = vt_count;
    rr_mode = 2;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < N_PIX; k++) pix[k] = 8'($urandom);
      send_image(N_PIX - 1, int'($urandom_range(1, 60)), $urandom, 3);
    end
    drain();
    rr_mode = 0;
    check("b2b_valid_top_count", vt_count, vt0 + 3);
    check("total_valid_top_count", vt_count, n_fired);
    check("pending_images", exp_img_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
